// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and word geometry.
// The CHK state exists only when LOADER_CHECKSUM_EN is defined.
package prog_loader_pkg;

  localparam int WORD_BYTES  = 4;
  localparam int ADDR_STRIDE = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
`ifdef LOADER_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input, instruction-memory write port and status of the program loader.
// The master side is the stream source/controller; the slave side is the loader.
interface prog_loader_if;

  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        load_enable;
  logic [31:0] write_addr;
  logic [31:0] write_data;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, load_enable, write_addr, write_data,
    input  cpu_hold, busy, done, error, words_loaded
  );

  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, load_enable, write_addr, write_data,
    output cpu_hold, busy, done, error, words_loaded
  );

endinterface

// File: rtl/prog_loader_byte_packer.sv
// Assembles accepted bytes big-endian into 32-bit words; word_ready_o fires
// combinationally with the last byte so word_o is the complete word that cycle.
module byte_packer
  import prog_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_ready_o
);

  localparam int CNT_W = $clog2(WORD_BYTES);
  localparam int SH_W  = 8 * (WORD_BYTES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SH_W-1:0]  shift_q, shift_d;

  assign word_o       = {shift_q, byte_i};
  assign word_ready_o = accept_i && (cnt_q == CNT_W'(WORD_BYTES - 1));

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clear_i) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (accept_i) begin
      shift_d = SH_W'({shift_q, byte_i});
      cnt_d   = cnt_q + 1'b1;  // wraps to 0 on the last byte of a word
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Streams a length-prefixed program into instruction memory while holding the CPU.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte (CHK state).
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 32,
  parameter int HDR_BYTES   = 2
) (
  input  logic          clock,
  input  logic          reset,
  prog_loader_if.slave  bus
);

  localparam int HDR_W  = HDR_BYTES * 8;
  localparam int HCNT_W = $clog2(HDR_BYTES + 1);
`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CHK;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  state_t            state_q, state_d;
  logic [HCNT_W-1:0] hdr_cnt_q, hdr_cnt_d;
  logic [HDR_W-1:0]  n_q, n_d, n_shift;
  logic [15:0]       words_q, words_d;
  logic [31:0]       waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              accept, pk_accept, pk_clear, pk_ready;
  logic [31:0]       pk_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        xor_q, xor_d;
`endif

  assign accept    = bus.byte_valid && bus.byte_ready;
  assign pk_accept = accept && (state_q == S_DATA);
  assign n_shift   = HDR_W'({n_q, bus.byte_data});

  byte_packer u_packer (
    .clock        (clock),
    .reset        (reset),
    .clear_i      (pk_clear),
    .accept_i     (pk_accept),
    .byte_i       (bus.byte_data),
    .word_o       (pk_word),
    .word_ready_o (pk_ready)
  );

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    n_d       = n_q;
    words_d   = words_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    pk_clear  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    xor_d     = xor_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.start) begin
          state_d   = S_HDR;
          hdr_cnt_d = '0;
          n_d       = '0;
          words_d   = '0;
          pk_clear  = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          xor_d     = '0;
`endif
        end
      end
      S_HDR: begin
        if (accept) begin
          n_d       = n_shift;
          hdr_cnt_d = hdr_cnt_q + 1'b1;
          if (hdr_cnt_q == HCNT_W'(HDR_BYTES - 1)) begin
            if (n_shift == '0)                          state_d = S_TAIL;
            else if (32'(n_shift) > 32'(DEPTH_WORDS))   state_d = S_ERR;
            else                                        state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
`ifdef LOADER_CHECKSUM_EN
        if (accept) xor_d = xor_q ^ bus.byte_data;
`endif
        // Latch address and data now so they stay stable through WRITE and after it.
        if (pk_ready) begin
          state_d = S_WRITE;
          waddr_d = 32'(words_q) * ADDR_STRIDE;
          wdata_d = pk_word;
        end
      end
      S_WRITE: begin
        words_d = words_q + 16'd1;
        state_d = (32'(words_q) + 1 < 32'(n_q)) ? S_DATA : S_TAIL;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) state_d = (bus.byte_data == xor_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      hdr_cnt_q <= '0;
      n_q       <= '0;
      words_q   <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
      xor_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      n_q       <= n_d;
      words_q   <= words_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
      xor_q     <= xor_d;
`endif
    end
  end

  always_comb begin
    bus.byte_ready  = 1'b0;
    bus.busy        = 1'b0;
    case (state_q)
      S_HDR, S_DATA: begin
        bus.byte_ready = 1'b1;
        bus.busy       = 1'b1;
      end
      S_WRITE: bus.busy = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        bus.byte_ready = 1'b1;
        bus.busy       = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign bus.load_enable  = (state_q == S_WRITE);
  assign bus.cpu_hold     = (state_q != S_DONE);
  assign bus.done         = (state_q == S_DONE);
  assign bus.error        = (state_q == S_ERR);
  assign bus.write_addr   = waddr_q;
  assign bus.write_data   = wdata_q;
  assign bus.words_loaded = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: normal load, oversize header, empty program,
// stalls, mid-load reset and (with LOADER_CHECKSUM_EN) checksum accept/reject.
module tb_prog_loader;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  prog_loader_if pif ();

  prog_loader #(.DEPTH_WORDS(32), .HDR_BYTES(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (pif)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int          wc[$];
  logic [7:0]  tx[$];

  always @(posedge clock) cyc <= cyc + 1;

  // Write log: every load_enable cycle seen at the falling edge.
  always @(negedge clock) begin
    if (pif.load_enable === 1'b1) begin
      wa.push_back(pif.write_addr);
      wd.push_back(pif.write_data);
      wc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    reset          = 1'b1;
    pif.start      = 1'b0;
    pif.byte_valid = 1'b0;
    pif.byte_data  = 8'h00;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    wa.delete();
    wd.delete();
    wc.delete();
  endtask

  task automatic pulse_start();
    @(posedge clock);
    #1 pif.start = 1'b1;
    @(posedge clock);
    #1 pif.start = 1'b0;
  endtask

  // Sends every byte in tx, waiting for byte_ready on each; drops valid at the end.
  task automatic send_all();
    while (tx.size() > 0) begin
      int   budget;
      logic sent;
      budget = 0;
      sent   = 1'b0;
      pif.byte_data  = tx.pop_front();
      pif.byte_valid = 1'b1;
      while (!sent) begin
        @(negedge clock);
        if (pif.byte_ready === 1'b1) begin
          @(posedge clock);
          #1 sent = 1'b1;
        end else begin
          budget++;
          if (budget > 20) begin
            check("send_timeout", 32'd0, 32'd1);
            tx.delete();
            pif.byte_valid = 1'b0;
            return;
          end
        end
      end
    end
    pif.byte_valid = 1'b0;
  endtask

  task automatic wait_end();
    int k;
    k = 0;
    while (!(pif.done === 1'b1 || pif.error === 1'b1) && k < 100) begin
      @(negedge clock);
      k++;
    end
    check("end_timeout", 32'(k < 100), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // ---------------- reset state ----------------
    apply_reset();
    check("rst_cpu_hold", 32'(pif.cpu_hold), 32'd1);
    check("rst_busy", 32'(pif.busy), 32'd0);
    check("rst_done", 32'(pif.done), 32'd0);
    check("rst_error", 32'(pif.error), 32'd0);
    check("rst_ready", 32'(pif.byte_ready), 32'd0);
    check("rst_load_en", 32'(pif.load_enable), 32'd0);
    check("rst_addr", pif.write_addr, 32'h0);
    check("rst_data", pif.write_data, 32'h0);
    check("rst_words", 32'(pif.words_loaded), 32'd0);

    // byte_valid in IDLE must not be consumed
    pif.byte_valid = 1'b1;
    pif.byte_data  = 8'hFF;
    repeat (3) @(posedge clock);
    #1;
    check("idle_no_ready", 32'(pif.byte_ready), 32'd0);
    pif.byte_valid = 1'b0;

    // ---------------- two-word load, streaming ----------------
    pulse_start();
    tx = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h3F};
`ifdef LOADER_CHECKSUM_EN
    tx.push_back(8'h14);
`endif
    send_all();
    wait_end();
    check("load2_nwrites", 32'(wa.size()), 32'd2);
    check("load2_addr0", wa[0], 32'h0);
    check("load2_data0", wd[0], 32'h2001000A);
    check("load2_addr1", wa[1], 32'h4);
    check("load2_data1", wd[1], 32'h0000003F);
    check("load2_spacing", 32'(wc[1] - wc[0]), 32'd5);
    check("load2_done", 32'(pif.done), 32'd1);
    check("load2_error", 32'(pif.error), 32'd0);
    check("load2_cpu_hold", 32'(pif.cpu_hold), 32'd0);
    check("load2_busy", 32'(pif.busy), 32'd0);
    check("load2_ready", 32'(pif.byte_ready), 32'd0);
    check("load2_words", 32'(pif.words_loaded), 32'd2);
    check("load2_addr_hold", pif.write_addr, 32'h4);
    check("load2_data_hold", pif.write_data, 32'h0000003F);
    repeat (4) @(posedge clock);
    #1;
    check("load2_sticky", 32'(pif.done), 32'd1);

    // ---------------- header larger than memory ----------------
    apply_reset();
    pulse_start();
    tx = '{8'h00, 8'h21};
    send_all();
    wait_end();
    check("ovf_error", 32'(pif.error), 32'd1);
    check("ovf_done", 32'(pif.done), 32'd0);
    check("ovf_nwrites", 32'(wa.size()), 32'd0);
    check("ovf_cpu_hold", 32'(pif.cpu_hold), 32'd1);
    check("ovf_ready", 32'(pif.byte_ready), 32'd0);
    repeat (4) @(posedge clock);
    #1;
    check("ovf_sticky", 32'(pif.error), 32'd1);

    // restart straight from ERR with a one-word program
    pulse_start();
    check("restart_error_clr", 32'(pif.error), 32'd0);
    tx = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
`ifdef LOADER_CHECKSUM_EN
    tx.push_back(8'hC9);
`endif
    send_all();
    wait_end();
    check("restart_nwrites", 32'(wa.size()), 32'd1);
    check("restart_addr", wa[0], 32'h0);
    check("restart_data", wd[0], 32'hCAFEF00D);
    check("restart_done", 32'(pif.done), 32'd1);

    // ---------------- header equal to capacity is accepted ----------------
    apply_reset();
    pulse_start();
    tx = '{8'h00, 8'h20};
    send_all();
    @(negedge clock);
    check("cap_error", 32'(pif.error), 32'd0);
    check("cap_busy", 32'(pif.busy), 32'd1);
    check("cap_ready", 32'(pif.byte_ready), 32'd1);

    // ---------------- empty program ----------------
    apply_reset();
    pulse_start();
    tx = '{8'h00, 8'h00};
    send_all();
`ifdef LOADER_CHECKSUM_EN
    @(negedge clock);
    check("empty_chk_busy", 32'(pif.busy), 32'd1);
    check("empty_chk_ready", 32'(pif.byte_ready), 32'd1);
    tx = '{8'h00};
    send_all();
`endif
    wait_end();
    check("empty_done", 32'(pif.done), 32'd1);
    check("empty_nwrites", 32'(wa.size()), 32'd0);
    check("empty_cpu_hold", 32'(pif.cpu_hold), 32'd0);

    // ---------------- stall mid-word ----------------
    apply_reset();
    pulse_start();
    tx = '{8'h00, 8'h01, 8'hDE, 8'hAD};
    send_all();
    repeat (7) @(posedge clock);
    #1;
    check("stall_nwrites", 32'(wa.size()), 32'd0);
    check("stall_busy", 32'(pif.busy), 32'd1);
    check("stall_words", 32'(pif.words_loaded), 32'd0);
    tx = '{8'hBE, 8'hEF};
`ifdef LOADER_CHECKSUM_EN
    tx.push_back(8'h22);
`endif
    send_all();
    wait_end();
    check("stall_nwrites_end", 32'(wa.size()), 32'd1);
    check("stall_addr", wa[0], 32'h0);
    check("stall_data", wd[0], 32'hDEADBEEF);
    check("stall_done", 32'(pif.done), 32'd1);

    // ---------------- reset during word 3 of 5 ----------------
    apply_reset();
    pulse_start();
    tx = '{8'h00, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    send_all();
    check("mid_nwrites_pre", 32'(wa.size()), 32'd2);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    check("mid_busy", 32'(pif.busy), 32'd0);
    check("mid_cpu_hold", 32'(pif.cpu_hold), 32'd1);
    check("mid_words", 32'(pif.words_loaded), 32'd0);
    check("mid_addr", pif.write_addr, 32'h0);
    check("mid_data", pif.write_data, 32'h0);
    pif.byte_valid = 1'b1;
    pif.byte_data  = 8'h0A;
    repeat (10) @(posedge clock);
    #1 pif.byte_valid = 1'b0;
    check("mid_no_more_writes", 32'(wa.size()), 32'd2);
    pulse_start();
    tx = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
`ifdef LOADER_CHECKSUM_EN
    tx.push_back(8'h08);
`endif
    send_all();
    wait_end();
    check("mid_reload_nwrites", 32'(wa.size()), 32'd3);
    check("mid_reload_addr", wa[2], 32'h0);
    check("mid_reload_data", wd[2], 32'h12345678);
    check("mid_reload_words", 32'(pif.words_loaded), 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // ---------------- checksum accept / reject ----------------
    apply_reset();
    pulse_start();
    tx = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    send_all();
    wait_end();
    check("csum_ok_done", 32'(pif.done), 32'd1);
    check("csum_ok_error", 32'(pif.error), 32'd0);
    check("csum_ok_data", wd[0], 32'h11223344);

    pulse_start();
    tx = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    send_all();
    wait_end();
    check("csum_bad_error", 32'(pif.error), 32'd1);
    check("csum_bad_done", 32'(pif.done), 32'd0);
    check("csum_bad_cpu_hold", 32'(pif.cpu_hold), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
